// File: rtl/cnn_pkg.sv
// cnn_pkg: definitions shared by the CNN post-processing stages.
//   - Default conv-result width and feature-map geometry.
//   - Row-sequencing state encoding used by relu_maxpool2x2.
//   - relu(): clamps a sign-extended value at zero.
package cnn_pkg;

  localparam int DATA_W_DEF = 22;
  localparam int MAP_W_DEF  = 4;
  localparam int MAP_H_DEF  = 4;

  // Working width for relu(). Callers sign-extend their narrower value to
  // this width and keep only the low bits of the result.
  localparam int RELU_W = 64;

  typedef enum logic {
    EVEN_ROW = 1'b0,
    ODD_ROW  = 1'b1
  } row_state_e;

  function automatic logic [RELU_W-1:0] relu(input logic [RELU_W-1:0] x);
    return x[RELU_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: half-width line buffer for the 2x2 pooling stage.
// Holds one horizontal pair maximum per window column, written while the
// even row of a window pair streams in and read back on the odd row.
//
// Ports:
//   clk      in   clock, rising edge
//   idx      in   entry index, shared by the write and the read port
//   wr_en    in   write wr_data into entry idx on the next edge
//   wr_data  in   value to store
//   rd_data  out  combinational read of entry idx
//
// Contents are not reset: every entry is written on an even row before it
// is read on the following odd row.
module pool_line_buf #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 21,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic [AW-1:0]    idx,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[idx] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[idx];

endmodule

// File: rtl/relu_maxpool2x2.sv
// relu_maxpool2x2: ReLU followed by 2x2 stride-2 max pooling over a
// raster-ordered MAP_W x MAP_H map of signed conv results.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   in_data holds a conv result
//   in_ready   out  sample accepted this cycle when in_valid is also high
//   in_data    in   signed conv result, row-major order
//   out_valid  out  out_data holds a pooled value
//   out_ready  in   downstream takes out_data this cycle
//   out_data   out  pooled value (unsigned, ReLU domain)
//   out_last   out  marks the last pooled value of a frame
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// out_valid/out_data/out_last hold until they are taken; in_ready is low
// whenever an untaken output is pending, so an output is never overwritten.
//
// The row-sequencing FSM state is row_state_q (EVEN_ROW / ODD_ROW).
module relu_maxpool2x2
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAP_W  = MAP_W_DEF,
  parameter int MAP_H  = MAP_H_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-2:0] out_data,
  output logic              out_last
);

  localparam int OUT_W    = DATA_W - 1;
  localparam int COL_W    = (MAP_W > 2) ? $clog2(MAP_W) : 1;
  localparam int ROW_W    = (MAP_H > 2) ? $clog2(MAP_H) : 1;
  localparam int LB_DEPTH = MAP_W / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAP_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAP_H - 1);

  // Registered state
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  row_state_e       row_state_q, row_state_d;
  logic [OUT_W-1:0] pair_q, pair_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;

  // Datapath
  logic [RELU_W-1:0] in_ext;
  logic [OUT_W-1:0]  r_val;
  logic [OUT_W-1:0]  m_val;
  logic [OUT_W-1:0]  lb_rd;
  logic [OUT_W-1:0]  pool_val;
  logic [LB_AW-1:0]  lb_idx;
  logic              accept;
  logic              col_wrap;
  logic              lb_wr_en;
  logic              load_out;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_wrap = accept && (col_q == COL_LAST);

  // Sign-extend to the package working width; the low OUT_W bits of the
  // clamped value are exactly in_data[DATA_W-2:0] for non-negative input.
  assign in_ext = {{(RELU_W - DATA_W){in_data[DATA_W-1]}}, in_data};
  assign r_val  = OUT_W'(relu(in_ext));

  // Odd column: max of the held even-column sample and this one.
  assign m_val    = (r_val > pair_q) ? r_val : pair_q;
  // Odd row: fold in the pair maximum from the row above.
  assign pool_val = (lb_rd > m_val) ? lb_rd : m_val;

  assign lb_idx = LB_AW'(col_q >> 1);

  pool_line_buf #(
    .DEPTH (LB_DEPTH),
    .WIDTH (OUT_W),
    .AW    (LB_AW)
  ) u_line_buf (
    .clk     (clk),
    .idx     (lb_idx),
    .wr_en   (lb_wr_en),
    .wr_data (m_val),
    .rd_data (lb_rd)
  );

  // Row FSM: next state and the per-row actions taken on odd columns.
  always_comb begin
    row_state_d = row_state_q;
    lb_wr_en    = 1'b0;
    load_out    = 1'b0;

    if (accept && col_q[0]) begin
      if (row_state_q == EVEN_ROW) begin
        lb_wr_en = 1'b1;
      end else begin
        load_out = 1'b1;
      end
    end

    if (col_wrap) begin
      if (row_q == ROW_LAST) begin
        row_state_d = EVEN_ROW;
      end else begin
        row_state_d = (row_state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
      end
    end
  end

  // Counters, pair register and output register.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    pair_d      = pair_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (accept) begin
      if (!col_q[0]) begin
        pair_d = r_val;
      end
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A new load takes priority over a same-cycle drain, keeping out_valid
    // high with the fresh value.
    if (load_out) begin
      out_valid_d = 1'b1;
      out_data_d  = pool_val;
      out_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      row_state_q <= EVEN_ROW;
      pair_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      row_state_q <= row_state_d;
      pair_q      <= pair_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
module tb_relu_maxpool2x2;
  import cnn_pkg::*;

  localparam int DATA_W = 22;
  localparam int OUT_W  = 21;
  localparam int MAP_W  = 4;
  localparam int MAP_H  = 4;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;

  always #5 clk = ~clk;

  relu_maxpool2x2 #(
    .DATA_W (DATA_W),
    .MAP_W  (MAP_W),
    .MAP_H  (MAP_H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  int errors = 0;
  int checks = 0;

  // Words are {last, value}.
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  logic [DATA_W-1:0] want_q[$];

  int basic_i [16] = '{1, -2, 3, 4, 5, 6, -7, 8, -1, -2, -3, -4, 9, 0, 2, 1};
  int neg_i   [16] = '{-5, -5, -5, -5, -5, -5, -5, -5,
                       -5, -5, -5, -5, -5, -5, -5, -5};
  int ext_i   [16] = '{2097151, -2097152, -2097152, -2097152,
                       0, 1, -2097152, -2097152,
                       -5, -5, -5, -5, -5, -5, -5, -5};

  // ---------------- reference model ----------------
  logic [OUT_W-1:0] frame_m [MAP_H][MAP_W];
  int               fidx = 0;
  int               m_row, m_col;
  logic [OUT_W-1:0] m_val;

  function automatic logic [OUT_W-1:0] model_relu(input logic [DATA_W-1:0] x);
    if ($signed(x) < 0) return '0;
    return x[OUT_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] max2(input logic [OUT_W-1:0] a,
                                             input logic [OUT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      fidx = 0;
      exp_q.delete();
    end else begin
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL out_valid: got %b want %b", out_valid, exp_q.size() != 0);
      end
      if (out_valid === 1'b1 && exp_q.size() != 0) begin
        checks++;
        if ({out_last, out_data} !== exp_q[0]) begin
          errors++;
          $display("FAIL out_word: got last=%b data=%0d want last=%b data=%0d",
                   out_last, out_data, exp_q[0][DATA_W-1], exp_q[0][OUT_W-1:0]);
        end
      end
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("FAIL in_ready: got %b want %b", in_ready, !out_valid || out_ready);
      end
      if (out_valid === 1'b1 && out_ready) begin
        got_q.push_back({out_last, out_data});
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready === 1'b1) begin
        m_row = fidx / MAP_W;
        m_col = fidx % MAP_W;
        frame_m[m_row][m_col] = model_relu(in_data);
        if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
          m_val = max2(max2(frame_m[m_row-1][m_col-1], frame_m[m_row-1][m_col]),
                       max2(frame_m[m_row][m_col-1], frame_m[m_row][m_col]));
          exp_q.push_back({(m_row == MAP_H - 1) && (m_col == MAP_W - 1), m_val});
        end
        fidx = (fidx + 1) % (MAP_W * MAP_H);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+#1; returns at posedge+#1 after the sample is taken.
  task automatic send_sample(input int d, input int gap);
    bit ok;
    ok = 1'b0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_frame(input int vals[16], input int max_gap);
    for (int k = 0; k < 16; k++) begin
      send_sample(vals[k], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic push_basic();
    want_q.push_back({1'b0, 21'd6});
    want_q.push_back({1'b0, 21'd8});
    want_q.push_back({1'b0, 21'd9});
    want_q.push_back({1'b1, 21'd2});
  endtask

  task automatic compare_got(input string name);
    chk({name, "_count"}, got_q.size(), want_q.size());
    for (int i = 0; i < want_q.size() && i < got_q.size(); i++) begin
      chk({name, "_word"}, got_q[i], want_q[i]);
    end
    got_q.delete();
    want_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 1);

    // Basic frame
    sync();
    send_frame(basic_i, 0);
    drain();
    push_basic();
    compare_got("basic");

    // All negative
    send_frame(neg_i, 0);
    drain();
    want_q.push_back({1'b0, 21'd0});
    want_q.push_back({1'b0, 21'd0});
    want_q.push_back({1'b0, 21'd0});
    want_q.push_back({1'b1, 21'd0});
    compare_got("allneg");

    // Extremes
    send_frame(ext_i, 0);
    drain();
    want_q.push_back({1'b0, 21'd2097151});
    want_q.push_back({1'b0, 21'd0});
    want_q.push_back({1'b0, 21'd0});
    want_q.push_back({1'b1, 21'd0});
    compare_got("extremes");

    // Backpressure: stall 3 cycles once 6 is presented
    fork
      send_frame(basic_i, 0);
      begin
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
          @(posedge clk);
          #1;
          if (out_valid === 1'b1) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) chk("bp_wait_timeout", 0, 1);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold_data", out_data, 6);
          chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    push_basic();
    compare_got("backpressure");

    // Reset mid-frame after 5 accepts
    for (int k = 0; k < 5; k++) send_sample(basic_i[k], 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_col", dut.col_q, 0);
    chk("midrst_row", dut.row_q, 0);
    chk("midrst_state", dut.row_state_q, EVEN_ROW);
    sync();
    send_frame(basic_i, 0);
    drain();
    push_basic();
    compare_got("midreset");

    // Back-to-back frames: continuous, then with random gaps
    for (int k = 0; k < 16; k++) send_sample(basic_i[k], 0);
    send_frame(basic_i, 2);
    drain();
    push_basic();
    push_basic();
    compare_got("b2b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
